// File: rtl/ctrl_pkg.sv
// Shared controller definitions: opcodes, sequencer state encoding and ISR field positions.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ALU = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h2;
  localparam logic [3:0] OP_LD  = 4'h3;
  localparam logic [3:0] OP_ST  = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_TRAP   = 3'd7
  } state_e;

  // RS and IMM deliberately overlap in the low byte of the instruction.
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 7;
  localparam int RS_LO  = 4;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

endpackage

// File: rtl/wait_timer.sv
// Memory wait counter: counts stalled cycles and flags when the wait limit is reached.
module wait_timer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic CLK,
  input  logic CLR,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear has priority so a fresh wait phase always starts counting from zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register, reset asynchronously with the rest of the controller.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A zero limit turns the timeout off entirely.
  assign expired = (TIMEOUT != 0) && (count_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetch handshake, ISR decode and execute/memory/writeback strobes.
module instr_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        START,
  input  logic        MRDY,
  input  logic        ZF,
  input  logic [15:0] ISR,
  output logic        MREQ,
  output logic        MWE,
  output logic        MIS,
  output logic        PC_INC,
  output logic        PC_LD,
  output logic        ALU_EN,
  output logic        RF_WE,
  output logic [3:0]  OP,
  output logic [3:0]  RD,
  output logic [3:0]  RS,
  output logic [7:0]  IMM,
  output logic        HALTED,
  output logic        ILLEGAL,
  output logic        TMO
);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [3:0] rd_q, rd_d;
  logic [3:0] rs_q, rs_d;
  logic [7:0] imm_q, imm_d;
  logic       illegal_q, illegal_d;
  logic       tmo_q, tmo_d;
  logic       in_wait;
  logic       wait_step;
  logic       wait_clear;
  logic       wait_expired;
  logic [3:0] isr_op;

  assign isr_op     = ISR[OP_HI:OP_LO];
  assign in_wait    = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign wait_step  = in_wait && !MRDY;
  assign wait_clear = !wait_step;

  wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .CLK     (CLK),
    .CLR     (CLR),
    .clear   (wait_clear),
    .enable  (wait_step),
    .expired (wait_expired)
  );

  // Next state, field capture in DECODE and the sticky fault flags.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs_d      = rs_q;
    imm_d     = imm_q;
    illegal_d = illegal_q;
    tmo_d     = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (START) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (MRDY) begin
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          state_d = ST_TRAP;
          tmo_d   = 1'b1;
        end
      end
      ST_DECODE: begin
        op_d  = isr_op;
        rd_d  = ISR[RD_HI:RD_LO];
        rs_d  = ISR[RS_HI:RS_LO];
        imm_d = ISR[IMM_HI:IMM_LO];
        case (isr_op)
          OP_NOP:                         state_d = ST_FETCH;
          OP_ALU, OP_LDI, OP_JMP, OP_JZ:  state_d = ST_EXEC;
          OP_LD, OP_ST:                   state_d = ST_MEM;
          OP_HLT:                         state_d = ST_HALT;
          default: begin
            state_d   = ST_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
      end
      ST_MEM: begin
        if (MRDY) begin
          state_d = (op_q == OP_LD) ? ST_WB : ST_FETCH;
        end else if (wait_expired) begin
          state_d = ST_TRAP;
          tmo_d   = 1'b1;
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        if (START) state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_TRAP;
      end
    endcase
  end

  // Datapath strobes follow the current state; only MIS/PC_INC look at MRDY.
  always_comb begin
    MREQ   = 1'b0;
    MWE    = 1'b0;
    MIS    = 1'b0;
    PC_INC = 1'b0;
    PC_LD  = 1'b0;
    ALU_EN = 1'b0;
    RF_WE  = 1'b0;
    HALTED = 1'b0;
    case (state_q)
      ST_FETCH: begin
        MREQ   = 1'b1;
        MIS    = MRDY;
        PC_INC = MRDY;
      end
      ST_EXEC: begin
        ALU_EN = (op_q == OP_ALU);
        RF_WE  = (op_q == OP_ALU) || (op_q == OP_LDI);
        PC_LD  = (op_q == OP_JMP) || ((op_q == OP_JZ) && ZF);
      end
      ST_MEM: begin
        MREQ = 1'b1;
        MWE  = (op_q == OP_ST);
      end
      ST_WB: begin
        RF_WE = 1'b1;
      end
      ST_HALT: begin
        HALTED = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State, decoded fields and sticky flags, all cleared by the asynchronous reset.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs_q      <= rs_d;
      imm_q     <= imm_d;
      illegal_q <= illegal_d;
      tmo_q     <= tmo_d;
    end
  end

  assign OP      = op_q;
  assign RD      = rd_q;
  assign RS      = rs_q;
  assign IMM     = imm_q;
  assign ILLEGAL = illegal_q;
  assign TMO     = tmo_q;

endmodule
